// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the add arbiter: FSM encoding and the round-robin pick rule.
package add_arb_pkg;

   localparam logic S_IDLE = 1'b0;
   localparam logic S_EXEC = 1'b1;

   localparam int MAX_N  = 8;
   localparam int PICK_W = 3;

   typedef enum logic {
      ST_IDLE = S_IDLE,
      ST_EXEC = S_EXEC
   } state_t;

   // First set bit of req scanning ptr, ptr+1, ... wrapping modulo n.
   function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                  input logic [PICK_W-1:0] ptr,
                                                  input int n);
      logic [PICK_W-1:0] win;
      logic              found;
      int                idx;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_N; k++) begin
         if (k < n && !found) begin
            idx = (int'(ptr) + k) % n;
            if (req[idx[PICK_W-1:0]]) begin
               win   = idx[PICK_W-1:0];
               found = 1'b1;
            end
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Requester-side bus of the add arbiter; slave is the arbiter, master the requester pool.
interface add_arbiter_if #(
   parameter int W   = 32,
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
);
   logic [N-1:0]   req;
   logic [N*W-1:0] in0_flat;
   logic [N*W-1:0] in1_flat;
   logic [N-1:0]   gnt;
   logic           busy;
   logic           res_valid;
   logic [IDW-1:0] res_id;
   logic [W-1:0]   res;
   logic           fsm_state;

   // Handshake: a requester holds req[i] high until it sees the one-cycle gnt[i]
   // pulse, which means its operands were latched; it should drop req[i] in that
   // cycle. res_valid is a one-cycle pulse with no ready: results cannot be stalled.
   modport slave (
      input  req, in0_flat, in1_flat,
      output gnt, busy, res_valid, res_id, res, fsm_state
   );

   modport master (
      output req, in0_flat, in1_flat,
      input  gnt, busy, res_valid, res_id, res, fsm_state
   );
endinterface

// File: rtl/add.sv
// Plain W-bit adder, sum modulo 2^W with the carry-out discarded.
module add #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   assign y = a + b;
endmodule

// File: rtl/add_arbiter_rr_picker.sv
// Combinational round-robin picker: winner index among req starting at ptr.
module rr_picker
   import add_arb_pkg::*;
#(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] win_id,
   output logic           win_vld
);
   logic [MAX_N-1:0]  req_ext;
   logic [PICK_W-1:0] pick;

   assign req_ext = MAX_N'(req);
   assign pick    = rr_pick(req_ext, PICK_W'(ptr), N);
   assign win_id  = pick[IDW-1:0];
   assign win_vld = |req;
endmodule

// File: rtl/add_arbiter.sv
// Shares one adder among N requesters: round-robin grant, operand latch, registered tagged sum.
module add_arbiter
   import add_arb_pkg::*;
#(
   parameter int W = 32,
   parameter int N = 4
) (
   input logic           clk,
   input logic           rstn,
   add_arbiter_if.slave  bus
);
   localparam int IDW = $clog2(N);

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] id;
   logic [IDW-1:0] win_id;
   logic           win_vld;
   logic [N-1:0]   win_onehot;
   logic [W-1:0]   op0;
   logic [W-1:0]   op1;
   logic [W-1:0]   sum;

   rr_picker #(.N(N)) u_picker (
      .req     (bus.req),
      .ptr     (ptr),
      .win_id  (win_id),
      .win_vld (win_vld)
   );

   add #(.W(W)) u_add (
      .a (op0),
      .b (op1),
      .y (sum)
   );

   assign win_onehot    = N'(1) << win_id;
   assign bus.fsm_state = state;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= ST_IDLE;
         ptr           <= '0;
         id            <= '0;
         op0           <= '0;
         op1           <= '0;
         bus.gnt       <= '0;
         bus.busy      <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_id    <= '0;
         bus.res       <= '0;
      end else begin
         bus.gnt       <= '0;
         bus.res_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  op0      <= bus.in0_flat[int'(win_id)*W +: W];
                  op1      <= bus.in1_flat[int'(win_id)*W +: W];
                  id       <= win_id;
                  bus.gnt  <= win_onehot;
                  bus.busy <= 1'b1;
                  // The winner drops to lowest priority for the next pick.
                  ptr      <= (int'(win_id) == N-1) ? '0 : win_id + 1'b1;
                  state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               bus.res       <= sum;
               bus.res_id    <= id;
               bus.res_valid <= 1'b1;
               bus.busy      <= 1'b0;
               state         <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed scenarios plus randomized ops against a reference model.
module tb_add_arbiter;
   import add_arb_pkg::*;

   localparam int W   = 32;
   localparam int N   = 4;
   localparam int IDW = $clog2(N);

   logic clk;
   logic rstn;

   add_arbiter_if #(.W(W), .N(N)) bus ();

   add_arbiter #(.W(W), .N(N)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state: priority pointer and per-requester operands.
   int           m_ptr;
   logic [W-1:0] op_a [N];
   logic [W-1:0] op_b [N];
   logic [IDW+W-1:0] exp_q [$];

   // Observations captured by drive_op.
   logic [N-1:0]   o_gnt;
   logic           o_busy;
   logic           o_rv1;
   logic           o_state;
   logic           o_rv2;
   logic [W-1:0]   o_res;
   logic [IDW-1:0] o_id;
   logic [N-1:0]   o_g2;
   logic           o_b2;

   function automatic int model_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (p + k) % N;
         if (r[i[IDW-1:0]]) return i;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i[IDW-1:0]] = 1'b1;
      return v;
   endfunction

   function automatic logic [W-1:0] model_sum(input int i);
      logic [W-1:0] s;
      s = op_a[i] + op_b[i];
      return s;
   endfunction

   task automatic apply_reset();
      bus.req = '0;
      rstn    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn  = 1'b1;
      m_ptr = 0;
   endtask

   task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      op_a[i] = a;
      op_b[i] = b;
      bus.in0_flat[i*W +: W] = a;
      bus.in1_flat[i*W +: W] = b;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) set_ops(i, $urandom, $urandom);
   endtask

   // Drives one request pattern through the grant and result cycles and captures outputs.
   task automatic drive_op(input logic [N-1:0] r, input logic keep);
      bus.req = r;
      @(posedge clk);
      @(negedge clk);
      o_gnt   = bus.gnt;
      o_busy  = bus.busy;
      o_rv1   = bus.res_valid;
      o_state = bus.fsm_state;
      if (!keep) bus.req = r & ~bus.gnt;
      @(posedge clk);
      @(negedge clk);
      o_rv2 = bus.res_valid;
      o_res = bus.res;
      o_id  = bus.res_id;
      o_g2  = bus.gnt;
      o_b2  = bus.busy;
      bus.req = '0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%b exp=0", bus.gnt); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
      checks++; if (bus.res !== '0) begin errors++; $display("FAIL reset_res got=%h exp=0", bus.res); end
      checks++; if (bus.res_id !== '0) begin errors++; $display("FAIL reset_res_id got=%0d exp=0", bus.res_id); end
      checks++; if (bus.fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%b exp=%b", bus.fsm_state, S_IDLE); end
   endtask

   task automatic test_single();
      set_ops(2, 32'd5, 32'd7);
      drive_op(4'b0100, 1'b0);
      checks++; if (o_gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", o_gnt); end
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", o_busy); end
      checks++; if (o_state !== S_EXEC) begin errors++; $display("FAIL single_state got=%b exp=%b", o_state, S_EXEC); end
      checks++; if (o_rv1 !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", o_rv1); end
      checks++; if (o_rv2 !== 1'b1) begin errors++; $display("FAIL single_res_valid got=%b exp=1", o_rv2); end
      checks++; if (o_res !== 32'd12) begin errors++; $display("FAIL single_res got=%0d exp=12", o_res); end
      checks++; if (o_id !== 2'd2) begin errors++; $display("FAIL single_res_id got=%0d exp=2", o_id); end
      checks++; if (o_g2 !== '0 || o_b2 !== 1'b0) begin errors++; $display("FAIL single_exec_end gnt=%b busy=%b exp gnt=0 busy=0", o_g2, o_b2); end
      m_ptr = 3;
   endtask

   task automatic test_all_req();
      logic [N-1:0] r;
      apply_reset();
      rand_ops();
      r = 4'b1111;
      for (int i = 0; i < N; i++) begin
         drive_op(r, 1'b0);
         checks++; if (o_gnt !== onehot(i)) begin errors++; $display("FAIL all_req_gnt step=%0d got=%b exp=%b", i, o_gnt, onehot(i)); end
         checks++; if (o_id !== IDW'(i) || o_res !== model_sum(i)) begin
            errors++; $display("FAIL all_req_res step=%0d got id=%0d res=%h exp id=%0d res=%h", i, o_id, o_res, i, model_sum(i));
         end
         r = r & ~onehot(i);
      end
      m_ptr = 0;
   endtask

   task automatic test_overflow();
      set_ops(1, 32'hFFFF_FFFF, 32'h0000_0002);
      drive_op(4'b0010, 1'b0);
      checks++; if (o_res !== 32'h0000_0001 || o_id !== 2'd1) begin
         errors++; $display("FAIL overflow_wrap got id=%0d res=%h exp id=1 res=00000001", o_id, o_res);
      end
      m_ptr = 2;
   endtask

   task automatic test_reset_exec();
      apply_reset();
      set_ops(0, 32'h1234, 32'h1);
      set_ops(1, 32'h10, 32'h20);
      set_ops(3, 32'h99, 32'h1);
      drive_op(4'b0001, 1'b0);
      checks++; if (o_res !== 32'h1235) begin errors++; $display("FAIL rst_exec_pre_res got=%h exp=00001235", o_res); end
      bus.req = 4'b0010;
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rst_exec_gnt got=%b exp=0010", bus.gnt); end
      rstn    = 1'b0;
      bus.req = '0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_no_valid got=%b exp=0", bus.res_valid); end
      checks++; if (bus.res !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_exec_clear got res=%h busy=%b exp res=0 busy=0", bus.res, bus.busy); end
      rstn  = 1'b1;
      m_ptr = 0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_late_valid got=%b exp=0", bus.res_valid); end
      drive_op(4'b1001, 1'b0);
      checks++; if (o_gnt !== 4'b0001) begin errors++; $display("FAIL rst_exec_next_gnt got=%b exp=0001", o_gnt); end
      checks++; if (o_id !== 2'd0 || o_res !== 32'h1235) begin errors++; $display("FAIL rst_exec_next_res got id=%0d res=%h exp id=0 res=00001235", o_id, o_res); end
      m_ptr = 1;
   endtask

   task automatic test_hold();
      apply_reset();
      rand_ops();
      drive_op(4'b1010, 1'b1);
      checks++; if (o_gnt !== 4'b0010) begin errors++; $display("FAIL hold_first got=%b exp=0010", o_gnt); end
      drive_op(4'b1010, 1'b0);
      checks++; if (o_gnt !== 4'b1000 || o_id !== 2'd3) begin errors++; $display("FAIL hold_second got gnt=%b id=%0d exp gnt=1000 id=3", o_gnt, o_id); end
      drive_op(4'b0010, 1'b0);
      checks++; if (o_gnt !== 4'b0010 || o_res !== model_sum(1)) begin errors++; $display("FAIL hold_third got gnt=%b res=%h exp gnt=0010 res=%h", o_gnt, o_res, model_sum(1)); end
      m_ptr = 2;
   endtask

   task automatic test_idle_wrap();
      apply_reset();
      rand_ops();
      drive_op(4'b0100, 1'b0);
      checks++; if (o_gnt !== 4'b0100) begin errors++; $display("FAIL idle_grant2 got=%b exp=0100", o_gnt); end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++; if (bus.gnt !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_quiet cycle=%0d gnt=%b busy=%b exp 0/0", c, bus.gnt, bus.busy); end
      end
      drive_op(4'b0101, 1'b0);
      checks++; if (o_gnt !== 4'b0001 || o_id !== 2'd0) begin errors++; $display("FAIL idle_wrap got gnt=%b id=%0d exp gnt=0001 id=0", o_gnt, o_id); end
      m_ptr = 1;
   endtask

   task automatic test_random();
      logic [N-1:0]     r;
      logic [IDW+W-1:0] exp_e;
      int               w;
      for (int it = 0; it < 40; it++) begin
         rand_ops();
         r = N'($urandom_range(0, (1 << N) - 1));
         if (r == '0) begin
            bus.req = '0;
            @(posedge clk);
            @(negedge clk);
            checks++; if (bus.gnt !== '0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL rand_idle it=%0d gnt=%b rv=%b exp 0/0", it, bus.gnt, bus.res_valid); end
         end else begin
            w = model_pick(r, m_ptr);
            exp_q.push_back({IDW'(w), model_sum(w)});
            drive_op(r, 1'($urandom_range(0, 1)));
            checks++; if (o_gnt !== onehot(w)) begin errors++; $display("FAIL rand_gnt it=%0d req=%b got=%b exp=%b", it, r, o_gnt, onehot(w)); end
            checks++; if (o_busy !== 1'b1 || o_rv1 !== 1'b0) begin errors++; $display("FAIL rand_grant_cycle it=%0d busy=%b rv=%b exp 1/0", it, o_busy, o_rv1); end
            checks++; if (o_rv2 !== 1'b1 || o_g2 !== '0 || o_b2 !== 1'b0) begin errors++; $display("FAIL rand_result_cycle it=%0d rv=%b gnt=%b busy=%b exp 1/0/0", it, o_rv2, o_g2, o_b2); end
            if (o_rv2 === 1'b1 && exp_q.size() > 0) begin
               exp_e = exp_q.pop_front();
               checks++; if ({o_id, o_res} !== exp_e) begin errors++; $display("FAIL rand_result it=%0d got id=%0d res=%h exp id=%0d res=%h", it, o_id, o_res, exp_e[IDW+W-1:W], exp_e[W-1:0]); end
            end
            m_ptr = (w + 1) % N;
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_missing_results got=%0d pending exp=0", exp_q.size()); end
   endtask

   initial begin
      rstn         = 1'b0;
      bus.req      = '0;
      bus.in0_flat = '0;
      bus.in1_flat = '0;
      m_ptr        = 0;
      test_reset();
      test_single();
      test_all_req();
      test_overflow();
      test_reset_exec();
      test_hold();
      test_idle_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
